sa_loop_ctrl: RTL and testbench

Tile-loop sequencer for the systolic-array controller. On `start` it latches a tile configuration and steps through weight-load, activation-feed and partial-sum-drain phases for each tile. It produces per-phase enable strobes and addresses for the array datapath. Its loop counters use the same terminal-count convention as the controller's `counter3` instances: a count value of N means N+1 iterations, 0..N inclusive.

---
 rtl/sa_loop_ctrl.sv | 117 +++++++++++
 tb/tb_sa_loop_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sa_loop_ctrl.sv
// sa_loop_ctrl: tile-loop sequencer for the systolic-array controller.
// On start it latches a tile configuration and walks every tile through
// weight-load (LOAD), activation-feed (COMPUTE) and partial-sum drain
// (DRAIN), then pulses done for one cycle and returns to IDLE.
// Loop counts follow the counter3 convention: a value of N means N+1
// iterations (0..N inclusive).
//
// Ports
//   clk, rstn            clock, async active-low reset
//   start                begin a job (sampled in IDLE only)
//   stall                freeze sequencing, gates the *_en strobes
//   cfg_rows/k/tiles     terminal counts, latched at start
//   busy, done           status (done is a one-cycle pulse)
//   w_load_en, a_feed_en, psum_drain_en   per-phase strobes
//   w_addr, a_addr, d_addr                per-phase addresses (0 outside phase)
//   tile_idx             current tile number
`ifndef SA_COUNTER_WIDTH
`define SA_COUNTER_WIDTH 3
`endif

module sa_loop_ctrl #(
  parameter int BIT_WIDTH = `SA_COUNTER_WIDTH
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               stall,
  input  logic [BIT_WIDTH:0] cfg_rows,
  input  logic [BIT_WIDTH:0] cfg_k,
  input  logic [BIT_WIDTH:0] cfg_tiles,
  output logic               busy,
  output logic               done,
  output logic               w_load_en,
  output logic               a_feed_en,
  output logic               psum_drain_en,
  output logic [BIT_WIDTH:0] w_addr,
  output logic [BIT_WIDTH:0] a_addr,
  output logic [BIT_WIDTH:0] d_addr,
  output logic [BIT_WIDTH:0] tile_idx
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_COMP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [BIT_WIDTH:0] rows_q, k_q, tiles_q;
  logic [BIT_WIDTH:0] pc_q;    // phase count, shared by all three phases
  logic [BIT_WIDTH:0] tile_q;

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next-state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  if (!stall && pc_q == rows_q) state_nxt = S_COMP;
      S_COMP:  if (!stall && pc_q == k_q)    state_nxt = S_DRAIN;
      S_DRAIN: if (!stall && pc_q == rows_q)
                 state_nxt = (tile_q == tiles_q) ? S_DONE : S_LOAD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // config latch and loop counters. Any phase exit clears the phase count,
  // so an all-ones terminal count wraps to 0 as a side effect of the exit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rows_q  <= '0;
      k_q     <= '0;
      tiles_q <= '0;
      pc_q    <= '0;
      tile_q  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          rows_q  <= cfg_rows;
          k_q     <= cfg_k;
          tiles_q <= cfg_tiles;
          pc_q    <= '0;
          tile_q  <= '0;
        end
        S_LOAD, S_COMP, S_DRAIN: if (!stall) begin
          if (state_nxt != state) pc_q <= '0;
          else                    pc_q <= pc_q + 1'b1;
          if (state == S_DRAIN && state_nxt == S_LOAD) tile_q <= tile_q + 1'b1;
        end
        S_DONE: tile_q <= '0;
        default: ;
      endcase
    end
  end

  // outputs: Moore decode, stall only gates the strobes
  always_comb begin
    busy          = (state != S_IDLE);
    done          = (state == S_DONE);
    w_load_en     = (state == S_LOAD)  && !stall;
    a_feed_en     = (state == S_COMP)  && !stall;
    psum_drain_en = (state == S_DRAIN) && !stall;
    w_addr        = (state == S_LOAD)  ? pc_q : '0;
    a_addr        = (state == S_COMP)  ? pc_q : '0;
    d_addr        = (state == S_DRAIN) ? pc_q : '0;
    tile_idx      = tile_q;
  end

endmodule

// File: tb/tb_sa_loop_ctrl.sv
// Self-checking bench for sa_loop_ctrl. The reference is a flat list of
// expected per-cycle steps (phase kind, address, tile) expanded from the
// job configuration; stalled cycles repeat the current step with strobes low.
module tb_sa_loop_ctrl;
  localparam int BW = 3;
  localparam int W  = BW + 1;

  logic         clk = 1'b0;
  logic         rstn, start, stall;
  logic [BW:0]  cfg_rows, cfg_k, cfg_tiles;
  logic         busy, done, w_load_en, a_feed_en, psum_drain_en;
  logic [BW:0]  w_addr, a_addr, d_addr, tile_idx;

  sa_loop_ctrl #(.BIT_WIDTH(BW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stall(stall),
    .cfg_rows(cfg_rows), .cfg_k(cfg_k), .cfg_tiles(cfg_tiles),
    .busy(busy), .done(done), .w_load_en(w_load_en), .a_feed_en(a_feed_en),
    .psum_drain_en(psum_drain_en), .w_addr(w_addr), .a_addr(a_addr),
    .d_addr(d_addr), .tile_idx(tile_idx)
  );

  always #5 clk = ~clk;

  localparam int OW = 5 + 4*W;
  logic [OW-1:0] obs;
  assign obs = {busy, done, w_load_en, a_feed_en, psum_drain_en,
                w_addr, a_addr, d_addr, tile_idx};

  // kind: 0 idle, 1 load, 2 compute, 3 drain, 4 done
  typedef struct {
    int          kind;
    logic [BW:0] addr;
    logic [BW:0] tile;
  } item_t;

  int npass = 0;
  int ntot  = 0;

  function automatic logic [OW-1:0] expv(input item_t it, input bit held);
    logic        b, d, we, ae, de;
    logic [BW:0] wa, aa, da;
    b  = (it.kind != 0);
    d  = (it.kind == 4);
    we = (it.kind == 1) && !held;
    ae = (it.kind == 2) && !held;
    de = (it.kind == 3) && !held;
    wa = (it.kind == 1) ? it.addr : '0;
    aa = (it.kind == 2) ? it.addr : '0;
    da = (it.kind == 3) ? it.addr : '0;
    return {b, d, we, ae, de, wa, aa, da, it.tile};
  endfunction

  task automatic chk(input string tag, input int cyc, input logic [OW-1:0] e);
    ntot++;
    assert (obs === e) npass++;
    else $error("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, e);
  endtask

  // Runs one job starting right after a posedge; returns right after a posedge.
  task automatic run_job(input int r, input int k, input int t, input int pct,
                         input bit scr, input logic [31:0] smask, input string tag);
    item_t q[$];
    item_t it;
    int    cyc, nst, done_cyc;
    bit    held;
    for (int tt = 0; tt <= t; tt++) begin
      for (int i = 0; i <= r; i++) begin it.kind = 1; it.addr = i[BW:0]; it.tile = tt[BW:0]; q.push_back(it); end
      for (int i = 0; i <= k; i++) begin it.kind = 2; it.addr = i[BW:0]; it.tile = tt[BW:0]; q.push_back(it); end
      for (int i = 0; i <= r; i++) begin it.kind = 3; it.addr = i[BW:0]; it.tile = tt[BW:0]; q.push_back(it); end
    end
    it.kind = 4; it.addr = '0; it.tile = t[BW:0]; q.push_back(it);
    it.kind = 0; it.tile = '0; q.push_back(it);

    cfg_rows = r[BW:0]; cfg_k = k[BW:0]; cfg_tiles = t[BW:0];
    start = 1'b1;
    stall = 1'($urandom % 2);
    it.kind = 0; it.addr = '0; it.tile = '0;
    @(negedge clk);
    chk({tag, "_idle"}, 0, expv(it, 1'b0));
    @(posedge clk); #1;

    cyc = 0; nst = 0; done_cyc = -1;
    for (int i = 0; i < q.size(); ) begin
      cyc++;
      stall = (cyc < 32 && smask[cyc]) || (($urandom % 100) < pct);
      if (scr && q[i].kind != 0) begin
        start     = 1'($urandom % 2);
        cfg_rows  = W'($urandom);
        cfg_k     = W'($urandom);
        cfg_tiles = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      held = stall && (q[i].kind >= 1 && q[i].kind <= 3);
      chk(tag, cyc, expv(q[i], held));
      if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
      if (held) nst++;
      else      i++;
      @(posedge clk); #1;
    end
    stall = 1'b0;
    start = 1'b0;
    ntot++;
    assert (done_cyc == ((r + 1) * 2 + (k + 1)) * (t + 1) + 1 + nst) npass++;
    else $error("FAIL %s_done_cycle got=%0d expected=%0d", tag, done_cyc,
                ((r + 1) * 2 + (k + 1)) * (t + 1) + 1 + nst);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; start = 1'b0; stall = 1'b0;
    cfg_rows = '0; cfg_k = '0; cfg_tiles = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", 0, '0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // directed cases from the test plan
    run_job(1, 2, 0, 0, 1'b0, 32'h0,  "single");
    run_job(0, 0, 2, 0, 1'b0, 32'h0,  "multi");
    run_job(1, 2, 0, 0, 1'b0, 32'h30, "stall");
    run_job(1, 2, 0, 0, 1'b1, 32'h0,  "ignored");
    run_job(0, 0, 0, 0, 1'b0, 32'h0,  "allzero");
    run_job(0, 15, 0, 0, 1'b0, 32'h0, "kmax");
    run_job(0, 0, 15, 0, 1'b0, 32'h0, "tilemax");

    // reset during COMPUTE: single-tile config, cycle 4 is mid-COMPUTE
    cfg_rows = 4'd1; cfg_k = 4'd2; cfg_tiles = 4'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ntot++;
    assert (a_feed_en === 1'b1 && a_addr === 4'd1) npass++;
    else $error("FAIL rst_pre got=%b/%h expected=1/1", a_feed_en, a_addr);
    #2 rstn = 1'b0;
    #1 chk("rst_async", 0, '0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("rst_hold", c, '0);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    run_job(1, 2, 0, 0, 1'b0, 32'h0, "post_rst");

    // randomized jobs with random stalls and scrambled inputs while busy
    for (int n = 0; n < 6; n++)
      run_job(int'($urandom % 4), int'($urandom % 4), int'($urandom % 3),
              25, 1'b1, 32'h0, "rand");
    run_job(2, 15, 1, 20, 1'b1, 32'h0, "rand_kmax");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
